// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: debounced push-button SPEED/MODE/PAUSE control
// driving a rotating 16-bit LED bank for the segment demo.
module led_shift_ctrl #(
    parameter logic [19:0] DEB_CYCLES  = 20'd500000,
    parameter logic [23:0] FAST_PERIOD = 24'd1048576,
    parameter logic [23:0] SLOW_PERIOD = 24'd4194304,
    parameter logic [15:0] LED_INIT    = 16'hFFF0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        BTN_SPEED,
    input  logic        BTN_DIR,
    input  logic        BTN_PAUSE,
    output logic [15:0] LED,
    output logic        SPEED,
    output logic        MODE,
    output logic        PAUSED,
    output logic        SHIFT_TICK
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_PAUSE = 1'b1
    } state_t;

    // Button lanes: [0] speed, [1] dir, [2] pause.
    logic [2:0]  w_btn;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_stable;
    logic [2:0]  r_stable_d;
    logic [19:0] r_deb_cnt [3];
    logic [2:0]  w_press;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_tick_cnt;
    logic [23:0] w_cnt_nxt;
    logic [23:0] w_period_m1;
    logic        w_tick;
    logic [15:0] r_led;
    logic        r_speed;
    logic        r_mode;

    assign w_btn = {BTN_PAUSE, BTN_DIR, BTN_SPEED};

    // Two-flop synchronizers; idle (released) level is 1.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive mismatches.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_stable   <= 3'b111;
            r_stable_d <= 3'b111;
            for (int i = 0; i < 3; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_stable_d <= r_stable;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_CYCLES - 20'd1) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 20'd1;
                end
            end
        end
    end

    // Press = stable level fell on the previous edge; releases are ignored.
    assign w_press = r_stable_d & ~r_stable;

    assign w_period_m1 = (r_speed ? FAST_PERIOD : SLOW_PERIOD) - 24'd1;

    // RUN/PAUSE state register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, tick and counter; a pause press suppresses the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_tick      = 1'b0;
        w_cnt_nxt   = '0;
        unique case (r_state)
            ST_RUN: begin
                w_tick = (r_tick_cnt == w_period_m1) && !w_press[2];
                if (w_press[2]) begin
                    w_state_nxt = ST_PAUSE;
                end else if (!w_press[0] && !w_tick) begin
                    w_cnt_nxt = r_tick_cnt + 24'd1;
                end
            end
            ST_PAUSE: begin
                if (w_press[2]) begin
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // Counter, SPEED/MODE toggles and LED rotation using the current MODE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_tick_cnt <= '0;
            r_speed    <= 1'b0;
            r_mode     <= 1'b0;
            r_led      <= LED_INIT;
        end else begin
            r_tick_cnt <= w_cnt_nxt;
            if (w_press[0]) begin
                r_speed <= ~r_speed;
            end
            if (w_press[1]) begin
                r_mode <= ~r_mode;
            end
            if (w_tick) begin
                r_led <= r_mode ? {r_led[0], r_led[15:1]}
                                : {r_led[14:0], r_led[15]};
            end
        end
    end

    assign LED        = r_led;
    assign SPEED      = r_speed;
    assign MODE       = r_mode;
    assign PAUSED     = (r_state == ST_PAUSE);
    assign SHIFT_TICK = w_tick;

endmodule
